rr_step_scheduler: RTL and testbench

- Round-robin scheduler that shares one three-step sequenced resource (STEP0 -> STEP1 -> STEP2) between PORTS requesters.
- Grants one requester at a time and walks the resource through the three steps, each for a programmed number of cycles.
- Reports completion to the granted port, then rotates priority.
- Sits between the per-port request logic and the shared step-sequenced datapath.

---
 rtl/rr_step_scheduler.sv | 179 +++++++++++++++++
 tb/tb_rr_step_scheduler.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/rr_step_scheduler.sv
// -----------------------------------------------------------------------------
// rr_step_scheduler
//
// Shares one three-step sequenced resource (STEP0 -> STEP1 -> STEP2) between
// PORTS requesters. A round-robin arbiter picks an owner in an IDLE cycle. The
// resource is then walked through the three steps. Each step lasts
// max(lenN, 1) cycles. On normal completion the owner receives a one-cycle
// done pulse, and priority rotates to the port after the owner.
//
// Ports:
//   clk         clock
//   rst         synchronous, active-high reset
//   req         per-port request level (bit i = port i)
//   len0..len2  step durations, sampled on entry to the respective step
//   abort       terminate the running sequence (ignored in IDLE)
//   grant       one-hot owner of the resource, zero in IDLE
//   busy        high in any state other than IDLE
//   step        0 = IDLE, 1 = STEP0, 2 = STEP1, 3 = STEP2
//   step_start  one-cycle pulse in the first cycle of each step
//   done        one-cycle pulse on the port whose sequence completed normally
// -----------------------------------------------------------------------------
module rr_step_scheduler #(
    parameter int PORTS = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [PORTS-1:0] req,
    input  logic [CNT_W-1:0] len0,
    input  logic [CNT_W-1:0] len1,
    input  logic [CNT_W-1:0] len2,
    input  logic             abort,
    output logic [PORTS-1:0] grant,
    output logic             busy,
    output logic [1:0]       step,
    output logic             step_start,
    output logic [PORTS-1:0] done
);

    localparam int PTR_W = (PORTS > 1) ? $clog2(PORTS) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_STEP0 = 2'd1,
        ST_STEP1 = 2'd2,
        ST_STEP2 = 2'd3
    } state_t;

    state_t           state_r;
    logic [PTR_W-1:0] ptr_r;
    logic [PTR_W-1:0] owner_r;
    logic [CNT_W-1:0] cnt_r;
    logic [PORTS-1:0] grant_r;
    logic [PORTS-1:0] done_r;
    logic             busy_r;
    logic             step_start_r;

    logic             win_valid_s;
    logic [PTR_W-1:0] win_idx_s;
    logic             step_last_s;
    int               cand_s;

    // One-hot decode of a port index.
    function automatic logic [PORTS-1:0] onehot(input logic [PTR_W-1:0] idx);
        logic [PORTS-1:0] v;
        v = {PORTS{1'b0}};
        v[idx] = 1'b1;
        return v;
    endfunction

    // Port index following idx, wrapping at PORTS-1 (PORTS need not be a power of two).
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] idx);
        logic [PTR_W-1:0] n;
        if (idx == PTR_W'(PORTS - 1)) begin
            n = {PTR_W{1'b0}};
        end else begin
            n = idx + {{(PTR_W-1){1'b0}}, 1'b1};
        end
        return n;
    endfunction

    // Round-robin search: first requesting port at or after ptr, wrapping.
    always_comb begin
        win_valid_s = 1'b0;
        win_idx_s   = {PTR_W{1'b0}};
        cand_s      = 0;
        for (int i = 0; i < PORTS; i++) begin
            cand_s = (int'(ptr_r) + i) % PORTS;
            if (!win_valid_s && req[cand_s]) begin
                win_valid_s = 1'b1;
                win_idx_s   = PTR_W'(cand_s);
            end else begin
                win_valid_s = win_valid_s;
            end
        end
    end

    // A counter loaded with 0 or 1 ends its step after one cycle.
    assign step_last_s = (cnt_r <= {{(CNT_W-1){1'b0}}, 1'b1});

    // Sequencer: arbitration in IDLE, step walking, abort and completion.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            ptr_r        <= {PTR_W{1'b0}};
            owner_r      <= {PTR_W{1'b0}};
            cnt_r        <= {CNT_W{1'b0}};
            grant_r      <= {PORTS{1'b0}};
            done_r       <= {PORTS{1'b0}};
            busy_r       <= 1'b0;
            step_start_r <= 1'b0;
        end else begin
            done_r       <= {PORTS{1'b0}};
            step_start_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (win_valid_s) begin
                        state_r      <= ST_STEP0;
                        owner_r      <= win_idx_s;
                        grant_r      <= onehot(win_idx_s);
                        busy_r       <= 1'b1;
                        step_start_r <= 1'b1;
                        cnt_r        <= len0;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_STEP0, ST_STEP1: begin
                    if (abort) begin
                        state_r <= ST_IDLE;
                        grant_r <= {PORTS{1'b0}};
                        busy_r  <= 1'b0;
                        ptr_r   <= next_ptr(owner_r);
                    end else if (step_last_s) begin
                        step_start_r <= 1'b1;
                        if (state_r == ST_STEP0) begin
                            state_r <= ST_STEP1;
                            cnt_r   <= len1;
                        end else begin
                            state_r <= ST_STEP2;
                            cnt_r   <= len2;
                        end
                    end else begin
                        cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                ST_STEP2: begin
                    // Abort in the final cycle suppresses the done pulse.
                    if (abort) begin
                        state_r <= ST_IDLE;
                        grant_r <= {PORTS{1'b0}};
                        busy_r  <= 1'b0;
                        ptr_r   <= next_ptr(owner_r);
                    end else if (step_last_s) begin
                        state_r <= ST_IDLE;
                        grant_r <= {PORTS{1'b0}};
                        busy_r  <= 1'b0;
                        done_r  <= grant_r;
                        ptr_r   <= next_ptr(owner_r);
                    end else begin
                        cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    grant_r <= {PORTS{1'b0}};
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign grant      = grant_r;
    assign busy       = busy_r;
    assign step       = state_r;
    assign step_start = step_start_r;
    assign done       = done_r;

endmodule

// File: tb/tb_rr_step_scheduler.sv
// -----------------------------------------------------------------------------
// tb_rr_step_scheduler
//
// Directed bench for rr_step_scheduler (PORTS = 4, CNT_W = 8). Each cycle the
// observed {grant, busy, step, step_start, done} is compared against a
// hand-computed expectation. busy is expected whenever step is non-zero.
// -----------------------------------------------------------------------------
module tb_rr_step_scheduler;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [7:0] len0;
    logic [7:0] len1;
    logic [7:0] len2;
    logic       abort;
    logic [3:0] grant;
    logic       busy;
    logic [1:0] step;
    logic       step_start;
    logic [3:0] done;

    int vectors;
    int miscompares;

    rr_step_scheduler #(.PORTS(4), .CNT_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .len0       (len0),
        .len1       (len1),
        .len2       (len2),
        .abort      (abort),
        .grant      (grant),
        .busy       (busy),
        .step       (step),
        .step_start (step_start),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [3:0] g, input logic [1:0] s,
                         input logic ss, input logic [3:0] d);
        logic [11:0] obs;
        logic [11:0] exp;
        obs = {grant, busy, step, step_start, done};
        exp = {g, (s != 2'd0), s, ss, d};
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed grant=%b busy=%b step=%0d ss=%b done=%b, expected grant=%b busy=%b step=%0d ss=%b done=%b",
                   tag, obs[11:8], obs[7], obs[6:5], obs[4], obs[3:0],
                   exp[11:8], exp[7], exp[6:5], exp[4], exp[3:0]);
        end
    endtask

    // Advance one cycle, then check.
    task automatic cyc(input string tag, input logic [3:0] g, input logic [1:0] s,
                       input logic ss, input logic [3:0] d);
        tick();
        check(tag, g, s, ss, d);
    endtask

    initial begin
        logic [3:0] oh;
        vectors     = 0;
        miscompares = 0;
        rst   = 1'b1;
        req   = 4'b0000;
        len0  = 8'd2;
        len1  = 8'd2;
        len2  = 8'd2;
        abort = 1'b0;
        tick();
        tick();
        check("reset", 4'b0000, 2'd0, 1'b0, 4'b0000);

        // Single request, every step two cycles long.
        rst = 1'b0;
        req = 4'b0100;
        cyc("t1_s0a", 4'b0100, 2'd1, 1'b1, 4'b0000);
        req = 4'b0000;
        cyc("t1_s0b", 4'b0100, 2'd1, 1'b0, 4'b0000);
        cyc("t1_s1a", 4'b0100, 2'd2, 1'b1, 4'b0000);
        cyc("t1_s1b", 4'b0100, 2'd2, 1'b0, 4'b0000);
        cyc("t1_s2a", 4'b0100, 2'd3, 1'b1, 4'b0000);
        cyc("t1_s2b", 4'b0100, 2'd3, 1'b0, 4'b0000);
        cyc("t1_done", 4'b0000, 2'd0, 1'b0, 4'b0100);
        cyc("t1_idle", 4'b0000, 2'd0, 1'b0, 4'b0000);

        // All ports requesting, one-cycle steps: strict rotation from port 0.
        rst  = 1'b1;
        req  = 4'b1111;
        len0 = 8'd1;
        len1 = 8'd1;
        len2 = 8'd1;
        tick();
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            oh = 4'b0001 << (k % 4);
            cyc("t2_s0", oh, 2'd1, 1'b1, 4'b0000);
            cyc("t2_s1", oh, 2'd2, 1'b1, 4'b0000);
            cyc("t2_s2", oh, 2'd3, 1'b1, 4'b0000);
            if (k == 4) begin
                req = 4'b0000;
            end
            cyc("t2_done", 4'b0000, 2'd0, 1'b0, oh);
        end

        // Zero lengths act as one; len1 change mid-STEP1 has no effect. ptr = 1.
        len0 = 8'd0;
        len1 = 8'd3;
        len2 = 8'd0;
        req  = 4'b0001;
        cyc("t3_s0", 4'b0001, 2'd1, 1'b1, 4'b0000);
        req = 4'b0000;
        cyc("t3_s1a", 4'b0001, 2'd2, 1'b1, 4'b0000);
        len1 = 8'd9;
        cyc("t3_s1b", 4'b0001, 2'd2, 1'b0, 4'b0000);
        cyc("t3_s1c", 4'b0001, 2'd2, 1'b0, 4'b0000);
        cyc("t3_s2", 4'b0001, 2'd3, 1'b1, 4'b0000);
        cyc("t3_done", 4'b0000, 2'd0, 1'b0, 4'b0001);
        len0 = 8'd1;
        len1 = 8'd3;
        len2 = 8'd1;

        // Abort in the second STEP1 cycle; ptr = 1, so port 1 wins first.
        req = 4'b0011;
        cyc("t4_s0", 4'b0010, 2'd1, 1'b1, 4'b0000);
        cyc("t4_s1a", 4'b0010, 2'd2, 1'b1, 4'b0000);
        cyc("t4_s1b", 4'b0010, 2'd2, 1'b0, 4'b0000);
        abort = 1'b1;
        cyc("t4_abort", 4'b0000, 2'd0, 1'b0, 4'b0000);
        abort = 1'b0;
        cyc("t4_next_arb", 4'b0001, 2'd1, 1'b1, 4'b0000);
        req = 4'b0000;
        cyc("t4b_s1a", 4'b0001, 2'd2, 1'b1, 4'b0000);
        cyc("t4b_s1b", 4'b0001, 2'd2, 1'b0, 4'b0000);
        cyc("t4b_s1c", 4'b0001, 2'd2, 1'b0, 4'b0000);
        cyc("t4b_s2", 4'b0001, 2'd3, 1'b1, 4'b0000);
        abort = 1'b1;
        cyc("t4_abort_last", 4'b0000, 2'd0, 1'b0, 4'b0000);
        // abort still high in IDLE must not block arbitration (ptr = 1 -> port 2).
        req = 4'b0100;
        cyc("t4_abort_idle", 4'b0100, 2'd1, 1'b1, 4'b0000);
        abort = 1'b0;

        // Owner drops req in STEP0, port 3 raises it.
        req = 4'b1000;
        cyc("t5_s1a", 4'b0100, 2'd2, 1'b1, 4'b0000);
        cyc("t5_s1b", 4'b0100, 2'd2, 1'b0, 4'b0000);
        cyc("t5_s1c", 4'b0100, 2'd2, 1'b0, 4'b0000);
        cyc("t5_s2", 4'b0100, 2'd3, 1'b1, 4'b0000);
        cyc("t5_done", 4'b0000, 2'd0, 1'b0, 4'b0100);
        cyc("t5_other", 4'b1000, 2'd1, 1'b1, 4'b0000);

        // After port 3 the pointer wraps to 0.
        req = 4'b0011;
        cyc("t6_s1a", 4'b1000, 2'd2, 1'b1, 4'b0000);
        cyc("t6_s1b", 4'b1000, 2'd2, 1'b0, 4'b0000);
        cyc("t6_s1c", 4'b1000, 2'd2, 1'b0, 4'b0000);
        cyc("t6_s2", 4'b1000, 2'd3, 1'b1, 4'b0000);
        cyc("t6_done", 4'b0000, 2'd0, 1'b0, 4'b1000);
        cyc("t6_wrap", 4'b0001, 2'd1, 1'b1, 4'b0000);
        cyc("t6b_s1a", 4'b0001, 2'd2, 1'b1, 4'b0000);
        cyc("t6b_s1b", 4'b0001, 2'd2, 1'b0, 4'b0000);
        cyc("t6b_s1c", 4'b0001, 2'd2, 1'b0, 4'b0000);
        cyc("t6b_s2", 4'b0001, 2'd3, 1'b1, 4'b0000);
        cyc("t6b_done", 4'b0000, 2'd0, 1'b0, 4'b0001);
        cyc("t7_s0", 4'b0010, 2'd1, 1'b1, 4'b0000);
        cyc("t7_s1", 4'b0010, 2'd2, 1'b1, 4'b0000);

        // Reset mid-sequence: ptr returns to 0, so port 0 beats port 1 afterwards.
        rst = 1'b1;
        cyc("t7_rst", 4'b0000, 2'd0, 1'b0, 4'b0000);
        rst = 1'b0;
        cyc("t7_post_rst", 4'b0001, 2'd1, 1'b1, 4'b0000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
